// File: rtl/histo_readout.sv
// Readout sequencer for the histogram accumulator: sweeps every bin once per frame
// (1..NUM_BINS-1 then 0) and streams the counts as a checksummed byte packet.
module histo_readout #(
  parameter int         NUM_BINS = 1024,
  parameter int         BIN_W    = 10,
  parameter int         SETTLE   = 4,
  parameter int         DWELL    = 3,
  parameter logic [7:0] SYNC     = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             histo_done,
  output logic             histo_rw,
  output logic [BIN_W-1:0] histo_bin,
  input  logic [23:0]      histo_data,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_HDR, S_DWELL, S_EMIT, S_TRAIL, S_DRAIN
  } state_t;

  localparam int CNT_MAX = (SETTLE > DWELL) ? SETTLE : DWELL;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [23:0]      hold_q, hold_d;
  logic [7:0]       csum_q, csum_d;
  logic [7:0]       frame_id_q, frame_id_d;
  logic             rw_q, rw_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             xfer;

  function automatic logic [BIN_W-1:0] next_bin(input logic [BIN_W-1:0] b);
    if (b == BIN_W'(NUM_BINS - 1)) return '0;
    return b + BIN_W'(1);
  endfunction

  function automatic logic [7:0] hold_byte(input logic [23:0] h, input logic [1:0] i);
    case (i)
      2'd0:    return h[23:16];
      2'd1:    return h[15:8];
      default: return h[7:0];
    endcase
  endfunction

  assign xfer = valid_q & out_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    csum_d     = csum_q;
    frame_id_d = frame_id_q;
    rw_d       = rw_q;
    bin_d      = bin_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    busy_d     = busy_q;
    overrun_d  = overrun_q | (histo_done & (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (histo_done) begin
          state_d = S_SETTLE;
          rw_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(SETTLE - 1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_HDR;
          valid_d = 1'b1;
          data_d  = SYNC;
          idx_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HDR: begin
        if (xfer) begin
          if (idx_q == 2'd0) begin
            data_d = frame_id_q;
            csum_d = frame_id_q;
            idx_d  = 2'd1;
          end else begin
            valid_d = 1'b0;
            bin_d   = BIN_W'(1);
            cnt_d   = CNT_W'(DWELL - 1);
            state_d = S_DWELL;
          end
        end
      end
      S_DWELL: begin
        // Last dwell cycle: accumulator read data has settled for this address
        if (cnt_q == '0) begin
          hold_d  = histo_data;
          data_d  = histo_data[23:16];
          valid_d = 1'b1;
          idx_d   = 2'd0;
          state_d = S_EMIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_EMIT: begin
        if (xfer) begin
          csum_d = csum_q + data_q;
          if (idx_q != 2'd2) begin
            idx_d  = idx_q + 2'd1;
            data_d = hold_byte(hold_q, idx_q + 2'd1);
          end else if (bin_q == '0) begin
            data_d  = csum_q + data_q;
            last_d  = 1'b1;
            state_d = S_TRAIL;
          end else begin
            valid_d = 1'b0;
            bin_d   = next_bin(bin_q);
            cnt_d   = CNT_W'(DWELL - 1);
            state_d = S_DWELL;
          end
        end
      end
      S_TRAIL: begin
        if (xfer) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          cnt_d   = CNT_W'(SETTLE - 1);
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Hold readout mode until the clear of bin 0 has passed the rw delay
        if (cnt_q == '0) begin
          rw_d       = 1'b1;
          busy_d     = 1'b0;
          frame_id_d = frame_id_q + 8'd1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      hold_q     <= '0;
      csum_q     <= '0;
      frame_id_q <= '0;
      rw_q       <= 1'b1;
      bin_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      csum_q     <= csum_d;
      frame_id_q <= frame_id_d;
      rw_q       <= rw_d;
      bin_q      <= bin_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign histo_rw  = rw_q;
  assign histo_bin = bin_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/histo_readout.md
# histo_readout

Readout sequencer for the histogram accumulator: on `histo_done` it switches the accumulator into read mode and sweeps every bin address. It captures each 24-bit count and streams the frame out as a byte packet with a valid/ready handshake. Bins are cleared behind the sweep by the accumulator's clear-on-read. The block sits between the accumulator and the host-link framer and is the sole driver of the accumulator's `rw` and `bin` inputs.

## Interface
- `NUM_BINS`, 1024 — bins per frame; power of two, at most 2^`BIN_W`.
- `BIN_W`, 10 — bin address width.
- `SETTLE`, 4 — cycles `histo_rw` is held low before the first address, and again after the last, to cover the accumulator's 4-stage `rw` delay.
- `DWELL`, 3 — cycles each bin address is held before `histo_data` is sampled (accumulator read latency is 2).
- `SYNC`, 8'hA5 — packet sync byte.

Ports:
- `clk` in 1 — clock.
- `rst_n` in 1 — reset, asynchronous assert, active-low.
- `histo_done` in 1 — one-cycle pulse from the accumulator at the end of an image.
- `histo_rw` out 1 — to accumulator `rw`: 1 = accumulate, 0 = readout/clear.
- `histo_bin` out `BIN_W` — to accumulator `bin`.
- `histo_data` in 24 — accumulator `data`.
- `out_data` out 8 — stream byte.
- `out_valid` out 1 — byte valid.
- `out_ready` in 1 — downstream accept.
- `out_last` out 1 — marks the final byte (checksum) of a packet.
- `busy` out 1 — high from `histo_done` acceptance until return to IDLE.
- `overrun` out 1 — sticky; set when `histo_done` arrives while busy; cleared only by reset.

## Operation
- Reset values: `histo_rw`=1, `histo_bin`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `overrun`=0, frame counter=0, checksum=0.
- Sweep order: bins 1, 2, …, `NUM_BINS`-1, then 0.
  - The accumulator latches data only when the bin address changes.
  - Its bin register rests at 0 after reset and after every sweep, so bin 0 must come last.
  - Packet bins therefore appear in this order.
- Packet layout: `SYNC`, frame_id[7:0], then 3 bytes per bin (count[23:16], [15:8], [7:0]), then checksum.
  - Total length 3·`NUM_BINS`+3 bytes.
  - Checksum = 8-bit sum mod 256 of frame_id and all data bytes. `SYNC` is excluded.
- FSM:
  - IDLE: `histo_rw`=1. On `histo_done`, go to SETTLE: set `busy`, drive `histo_rw`=0, load the settle counter.
  - SETTLE: count `SETTLE` cycles, then go to HDR.
  - HDR: emit `SYNC`, then frame_id. Checksum is initialised to frame_id. After frame_id is accepted, drive `histo_bin`=1 and go to DWELL.
  - DWELL: hold `histo_bin` for `DWELL` cycles. On the last cycle, register `histo_data` into a 24-bit holding register, then go to EMIT.
  - EMIT: emit the 3 holding bytes MSB first and add each to the checksum on transfer. After the 3rd is accepted:
    - if the bin just emitted was 0, go to TRAIL;
    - otherwise advance `histo_bin` (wrapping `NUM_BINS`-1 to 0) and go to DWELL.
  - TRAIL: emit checksum with `out_last`=1. On acceptance go to DRAIN.
  - DRAIN: keep `histo_rw`=0 and `histo_bin`=0 for `SETTLE` cycles so the final clear write completes. Then set `histo_rw`=1, clear `busy`, increment frame_id (8-bit wrap), and go to IDLE.
- `histo_bin` changes only on the DWELL entry cycle. It is held through EMIT regardless of backpressure.
- `histo_done` outside IDLE is ignored for sequencing and sets `overrun`.
- Reset asserted mid-frame: all state returns to reset values immediately. The partial packet is abandoned with no `out_last`. The accumulator resumes accumulating with possibly uncleared bins; a full clear is the system's responsibility.

## Timing
- `histo_done` at cycle T: `histo_rw`=0 from T+1 and `busy`=1 from T+1. First `out_valid` (SYNC) at T+1+`SETTLE`.
- AXI-style handshake: a transfer occurs on `out_valid`&`out_ready`. While `out_valid`=1 and `out_ready`=0, `out_data`/`out_last` hold stable. `out_valid` never drops without a transfer.
- With `out_ready` tied high: one byte per cycle in HDR/EMIT/TRAIL; each bin takes `DWELL`+3 cycles.
- Full frame with `out_ready`=1: 2·`SETTLE` + 2 + `NUM_BINS`·(`DWELL`+3) + 1 cycles from `histo_done` to `busy` low, plus or minus 1 for the registered transition.
- `histo_data` sample point: the `DWELL`-th cycle after the `histo_bin` update, i.e. 2 cycles of accumulator latency plus 1 margin.

## Test plan
- Accumulator behavioural model with bin k = k·3: `histo_done`, `out_ready`=1 -> 3075 bytes; A5, 00, bin 1 = 00 00 03, …, bin 0 = 00 00 00 last; checksum correct; `out_last` only on byte 3075; model shows all bins zero afterwards.
- Random `out_ready` (50% duty) -> byte sequence identical to the previous case; `out_data` stable during stalls; `histo_bin` unchanged across stalls.
- Bin 1023 = 0xFFFFFF, others 0 -> bytes FF FF FF at bin 1023's slot; checksum = (frame_id + 0xFD) mod 256.
- Second `histo_done` mid-sweep -> `overrun`=1, packet unaffected; third frame after IDLE has frame_id 01.
- `rst_n` low during EMIT of bin 500 -> next cycle `out_valid`=0, `histo_rw`=1, `busy`=0; next `histo_done` starts a fresh packet with frame_id 00.
- 256 back-to-back frames -> frame_id wraps FF -> 00; `busy` low for at least 1 cycle between frames.
